id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe_pkg.sv | 78 +++++++
 rtl/id_fwd_mux.sv | 40 ++++
 rtl/id_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_id_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: shared decode constants for the ID stage.
//   - MIPS opcode / SPECIAL funct codes for the supported subset
//   - aluop / alusel codes presented to EX
//   - NOP register address and the all-zero NOP instruction word
//   - id_ex_t: the ID/EX pipeline register layout, plus its bubble value
package id_pipe_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    // ALU operation codes
    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_SRL   = 8'h02;
    localparam logic [7:0] ALU_SRA   = 8'h03;
    localparam logic [7:0] ALU_ADDU  = 8'h21;
    localparam logic [7:0] ALU_SUBU  = 8'h23;
    localparam logic [7:0] ALU_AND   = 8'h24;
    localparam logic [7:0] ALU_OR    = 8'h25;
    localparam logic [7:0] ALU_XOR   = 8'h26;
    localparam logic [7:0] ALU_NOR   = 8'h27;
    localparam logic [7:0] ALU_ADDIU = 8'h56;
    localparam logic [7:0] ALU_SLL   = 8'h7C;
    localparam logic [7:0] ALU_LW    = 8'hE3;

    // ALU result-select codes
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_LDST  = 3'b111;

    localparam logic [4:0]  NOP_REG  = 5'd0;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic        is_load;
        logic        invalid;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:   1'b0,
        pc:      '0,
        aluop:   ALU_NOP,
        alusel:  SEL_NOP,
        reg1:    '0,
        reg2:    '0,
        wd:      NOP_REG,
        wreg:    1'b0,
        is_load: 1'b0,
        invalid: 1'b0
    };

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: selects one ALU operand.
//   rd_en/addr      register read request for this operand
//   rf_data         register-file read data
//   imm             value used when no register is read (immediate / shamt)
//   ex_* / mem_*    in-flight results available for forwarding
//   data            selected operand
// EX is the younger producer, so it takes priority over MEM.
module id_fwd_mux
    import id_pipe_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic        rd_en,
    input  logic [4:0]  addr,
    input  logic [31:0] rf_data,
    input  logic [31:0] imm,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_wd,
    input  logic [31:0] ex_wdata,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_wd,
    input  logic [31:0] mem_wdata,
    output logic [31:0] data
);

    always_comb begin
        data = imm;
        if (rd_en) begin
            if (addr == NOP_REG)
                data = '0;
            else if ((FWD_EN != 0) && ex_wreg && (ex_wd == addr))
                data = ex_wdata;
            else if ((FWD_EN != 0) && mem_wreg && (mem_wd == addr))
                data = mem_wdata;
            else
                data = rf_data;
        end
    end

endmodule

// File: rtl/id_pipe.sv
// id_pipe: instruction decode stage with operand forwarding, load-use
// hazard detection and the ID/EX pipeline register.
//   clk, rst                 clock, synchronous active-high reset
//   pc_i, inst_i, valid_i    instruction from IF/ID (valid_i=0 is a bubble)
//   reg{1,2}_read_o/addr_o   register-file read requests (combinational)
//   reg{1,2}_data_i          register-file read data (same cycle)
//   ex_* / mem_* inputs      in-flight results for forwarding / hazard check
//   stall_i, flush_i         downstream hold / squash
//   stallreq_o               request to freeze PC and IF/ID
//   ex_* outputs             registered decode result for EX
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int FWD_EN     = 1,
    parameter int LOADUSE_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        valid_i,
    output logic        reg1_read_o,
    output logic        reg2_read_o,
    output logic [4:0]  reg1_addr_o,
    output logic [4:0]  reg2_addr_o,
    input  logic [31:0] reg1_data_i,
    input  logic [31:0] reg2_data_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_wd_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_is_load_i,
    input  logic        mem_wreg_i,
    input  logic [4:0]  mem_wd_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [7:0]  ex_aluop_o,
    output logic [2:0]  ex_alusel_o,
    output logic [31:0] ex_reg1_o,
    output logic [31:0] ex_reg2_o,
    output logic [4:0]  ex_wd_o,
    output logic        ex_wreg_o,
    output logic        ex_is_load_o,
    output logic        ex_invalid_o
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign shamt = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    logic        rd1, rd2;
    logic [31:0] imm1, imm2;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg, is_load, invalid;

    // Decode. Anything not matched below falls through as an invalid NOP.
    always_comb begin
        rd1     = 1'b0;
        rd2     = 1'b0;
        imm1    = '0;
        imm2    = '0;
        aluop   = ALU_NOP;
        alusel  = SEL_NOP;
        wd      = NOP_REG;
        wreg    = 1'b0;
        is_load = 1'b0;
        invalid = 1'b1;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                rd1     = 1'b1;
                imm2    = {16'h0, imm16};
                aluop   = (op == OP_ORI)  ? ALU_OR  :
                          (op == OP_ANDI) ? ALU_AND : ALU_XOR;
                alusel  = SEL_LOGIC;
                wd      = rt;
                wreg    = 1'b1;
                invalid = 1'b0;
            end
            OP_ADDIU, OP_LW: begin
                rd1     = 1'b1;
                imm2    = {{16{imm16[15]}}, imm16};
                aluop   = (op == OP_LW) ? ALU_LW : ALU_ADDIU;
                alusel  = (op == OP_LW) ? SEL_LDST : SEL_ARITH;
                is_load = (op == OP_LW);
                wd      = rt;
                wreg    = 1'b1;
                invalid = 1'b0;
            end
            OP_LUI: begin
                imm2    = {imm16, 16'h0};
                aluop   = ALU_OR;
                alusel  = SEL_LOGIC;
                wd      = rt;
                wreg    = 1'b1;
                invalid = 1'b0;
            end
            OP_SPECIAL: begin
                if (inst_i == INST_NOP) begin
                    // canonical NOP (SLL $0,$0,0): valid but writes nothing
                    invalid = 1'b0;
                end else begin
                    case (funct)
                        FN_AND, FN_OR, FN_XOR, FN_NOR, FN_ADDU, FN_SUBU: begin
                            rd1     = 1'b1;
                            rd2     = 1'b1;
                            wd      = rd;
                            wreg    = 1'b1;
                            invalid = 1'b0;
                            case (funct)
                                FN_AND:  begin aluop = ALU_AND;  alusel = SEL_LOGIC; end
                                FN_OR:   begin aluop = ALU_OR;   alusel = SEL_LOGIC; end
                                FN_XOR:  begin aluop = ALU_XOR;  alusel = SEL_LOGIC; end
                                FN_NOR:  begin aluop = ALU_NOR;  alusel = SEL_LOGIC; end
                                FN_ADDU: begin aluop = ALU_ADDU; alusel = SEL_ARITH; end
                                default: begin aluop = ALU_SUBU; alusel = SEL_ARITH; end
                            endcase
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            rd2     = 1'b1;
                            imm1    = {27'h0, shamt};
                            aluop   = (funct == FN_SLL) ? ALU_SLL :
                                      (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                            alusel  = SEL_SHIFT;
                            wd      = rd;
                            wreg    = 1'b1;
                            invalid = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign reg1_read_o = ~rst & rd1;
    assign reg2_read_o = ~rst & rd2;
    assign reg1_addr_o = rst ? NOP_REG : rs;
    assign reg2_addr_o = rst ? NOP_REG : rt;

    // A load in EX cannot forward until it reaches MEM, so a dependent
    // instruction must wait one cycle.
    logic hazard;
    assign hazard = ex_is_load_i && ex_wreg_i && (ex_wd_i != NOP_REG) &&
                    ((rd1 && (ex_wd_i == rs)) || (rd2 && (ex_wd_i == rt)));
    assign stallreq_o = (LOADUSE_EN != 0) && !rst && valid_i && hazard;

    logic [31:0] opnd1, opnd2;

    id_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd1 (
        .rd_en(rd1), .addr(rs), .rf_data(reg1_data_i), .imm(imm1),
        .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
        .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .data(opnd1)
    );

    id_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd2 (
        .rd_en(rd2), .addr(rt), .rf_data(reg2_data_i), .imm(imm2),
        .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
        .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .data(opnd2)
    );

    id_ex_t dec, q;

    assign dec = '{
        valid:   1'b1,
        pc:      pc_i,
        aluop:   aluop,
        alusel:  alusel,
        reg1:    opnd1,
        reg2:    opnd2,
        wd:      wd,
        wreg:    wreg,
        is_load: is_load,
        invalid: invalid
    };

    // stall_i holds everything, including over our own stall request.
    always_ff @(posedge clk) begin
        if (rst || flush_i)
            q <= ID_EX_BUBBLE;
        else if (stall_i)
            q <= q;
        else if (stallreq_o || !valid_i)
            q <= ID_EX_BUBBLE;
        else
            q <= dec;
    end

    assign ex_valid_o   = q.valid;
    assign ex_pc_o      = q.pc;
    assign ex_aluop_o   = q.aluop;
    assign ex_alusel_o  = q.alusel;
    assign ex_reg1_o    = q.reg1;
    assign ex_reg2_o    = q.reg2;
    assign ex_wd_o      = q.wd;
    assign ex_wreg_o    = q.wreg;
    assign ex_is_load_o = q.is_load;
    assign ex_invalid_o = q.invalid;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed vectors for id_pipe. Stimulus pushes the expected
// ID/EX contents tagged with the cycle they must appear in; a monitor on
// the falling edge pops and compares. Combinational outputs are checked
// directly by the stimulus before each edge.
module tb_id_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        ld;
        logic        inv;
    } exp_t;

    typedef struct {
        int    cyc;
        string name;
        exp_t  e;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, inst_i;
    logic        valid_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stall_i, flush_i, stallreq_o;
    logic        ex_valid_o, ex_wreg_o, ex_is_load_o, ex_invalid_o;
    logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [4:0]  ex_wd_o;

    id_pipe dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
        .mem_wdata_i(mem_wdata_i), .stall_i(stall_i), .flush_i(flush_i),
        .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o),
        .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_is_load_o(ex_is_load_o), .ex_invalid_o(ex_invalid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    exp_t last;
    localparam exp_t BUB = '0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] aluop,
                                input logic [2:0] sel, input logic [31:0] r1, r2,
                                input logic [4:0] wd, input logic wreg, ld, inv);
        exp_t e;
        e = '{valid: 1'b1, pc: pc, aluop: aluop, alusel: sel, r1: r1, r2: r2,
              wd: wd, wreg: wreg, ld: ld, inv: inv};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Queue the expected register contents, then advance one cycle.
    task automatic step(input string name, input exp_t e);
        sb.push_back('{cyc: cyc + 1, name: name, e: e});
        last = e;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever is due this cycle.
    always @(negedge clk) begin
        exp_t act;
        act = '{valid: ex_valid_o, pc: ex_pc_o, aluop: ex_aluop_o, alusel: ex_alusel_o,
                r1: ex_reg1_o, r2: ex_reg2_o, wd: ex_wd_o, wreg: ex_wreg_o,
                ld: ex_is_load_o, inv: ex_invalid_o};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_t s;
            s = sb.pop_front();
            checks++;
            if (s.cyc != cyc) begin
                errors++;
                $display("FAIL %s: output missed at cycle %0d, due %0d", s.name, cyc, s.cyc);
            end else if (act !== s.e) begin
                errors++;
                $display("FAIL %s: actual %h required %h", s.name, act, s.e);
            end
        end
    end

    task automatic clr_fwd();
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
    endtask

    task automatic set(input logic [31:0] pc, input logic [31:0] inst, input logic v);
        pc_i = pc; inst_i = inst; valid_i = v;
    endtask

    localparam logic [31:0] I_ORI   = 32'h3401_1100; // ORI   $1,$0,0x1100
    localparam logic [31:0] I_ADDU  = 32'h0022_1821; // ADDU  $3,$1,$2
    localparam logic [31:0] I_LUI   = 32'h3C07_1234; // LUI   $7,0x1234
    localparam logic [31:0] I_ADDIU = 32'h2422_FFFF; // ADDIU $2,$1,-1
    localparam logic [31:0] I_LW    = 32'h8C24_0008; // LW    $4,8($1)
    localparam logic [31:0] I_SRA   = 32'h0002_30C3; // SRA   $6,$2,3
    localparam logic [31:0] I_ANDI  = 32'h3021_8000; // ANDI  $1,$1,0x8000
    localparam logic [31:0] I_OR    = 32'h0080_2825; // OR    $5,$4,$0
    localparam logic [31:0] I_BAD   = 32'hFC00_0000; // opcode 111111

    initial begin
        rst = 1; stall_i = 0; flush_i = 0;
        reg1_data_i = 0; reg2_data_i = 0;
        clr_fwd();
        set(32'h0, I_ORI, 1'b1);
        @(posedge clk);
        #1;

        // reset: combinational outputs forced low even with a hazard present
        ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd4;
        set(32'h0, I_OR, 1'b1);
        #1;
        chk("rst_rd1", {31'h0, reg1_read_o}, 32'd0);
        chk("rst_a2", {27'h0, reg2_addr_o}, 32'd0);
        chk("rst_stallreq", {31'h0, stallreq_o}, 32'd0);
        step("rst_bubble", BUB);

        rst = 0;
        clr_fwd();
        reg1_data_i = 32'hDEAD;
        set(32'h100, I_ORI, 1'b1);
        #1;
        chk("ori_rd1", {31'h0, reg1_read_o}, 32'd1);
        chk("ori_rd2", {31'h0, reg2_read_o}, 32'd0);
        chk("ori_a2", {27'h0, reg2_addr_o}, 32'd1);
        step("ori", mk(32'h100, 8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1, 0, 0));

        // forwarding: rs from EX, rt from MEM
        reg1_data_i = 0; reg2_data_i = 0;
        ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 5;
        mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 7;
        set(32'h104, I_ADDU, 1'b1);
        step("addu_fwd", mk(32'h104, 8'h21, 3'd4, 5, 7, 5'd3, 1, 0, 0));

        // EX and MEM both target $1: EX wins; rt falls back to regfile
        mem_wd_i = 5'd1; mem_wdata_i = 9; reg2_data_i = 32'h22;
        set(32'h108, I_ADDU, 1'b1);
        step("addu_prio", mk(32'h108, 8'h21, 3'd4, 5, 32'h22, 5'd3, 1, 0, 0));

        clr_fwd();
        set(32'h10C, I_LUI, 1'b1);
        #1;
        chk("lui_rd1", {31'h0, reg1_read_o}, 32'd0);
        step("lui", mk(32'h10C, 8'h25, 3'd1, 0, 32'h1234_0000, 5'd7, 1, 0, 0));

        reg1_data_i = 32'h10;
        set(32'h110, I_ADDIU, 1'b1);
        step("addiu", mk(32'h110, 8'h56, 3'd4, 32'h10, 32'hFFFF_FFFF, 5'd2, 1, 0, 0));

        set(32'h114, I_LW, 1'b1);
        step("lw", mk(32'h114, 8'hE3, 3'd7, 32'h10, 32'h8, 5'd4, 1, 1, 0));

        reg2_data_i = 32'h8000_0000;
        set(32'h118, I_SRA, 1'b1);
        #1;
        chk("sra_rd1", {31'h0, reg1_read_o}, 32'd0);
        chk("sra_rd2", {31'h0, reg2_read_o}, 32'd1);
        chk("sra_a2", {27'h0, reg2_addr_o}, 32'd2);
        step("sra", mk(32'h118, 8'h03, 3'd2, 32'd3, 32'h8000_0000, 5'd6, 1, 0, 0));

        set(32'h11C, I_ANDI, 1'b1);
        step("andi", mk(32'h11C, 8'h24, 3'd1, 32'h10, 32'h8000, 5'd1, 1, 0, 0));

        // load-use: stall one cycle, then forward from MEM
        ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd4;
        set(32'h120, I_OR, 1'b1);
        #1;
        chk("lu_stallreq", {31'h0, stallreq_o}, 32'd1);
        step("lu_bubble", BUB);

        clr_fwd();
        mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'hAB;
        #1;
        chk("lu_clear", {31'h0, stallreq_o}, 32'd0);
        step("lu_issue", mk(32'h120, 8'h25, 3'd1, 32'hAB, 0, 5'd5, 1, 0, 0));

        // non-load producer in EX: forwarding, no stall
        clr_fwd();
        ex_wreg_i = 1; ex_wd_i = 5'd4; ex_wdata_i = 32'h77;
        #1;
        chk("nolu_stallreq", {31'h0, stallreq_o}, 32'd0);
        clr_fwd();

        set(32'h124, I_BAD, 1'b1);
        step("invalid", mk(32'h124, 8'h00, 3'd0, 0, 0, 5'd0, 0, 0, 1));

        set(32'h128, 32'h0, 1'b1);
        step("nop", mk(32'h128, 8'h00, 3'd0, 0, 0, 5'd0, 0, 0, 0));

        set(32'h12C, I_ORI, 1'b0);
        step("vld0_bubble", BUB);

        // stall holds three cycles, then flush+stall squashes
        set(32'h130, I_ORI, 1'b1);
        step("pre_stall", mk(32'h130, 8'h25, 3'd1, 0, 32'h1100, 5'd1, 1, 0, 0));
        stall_i = 1;
        set(32'h134, I_ADDU, 1'b1);
        for (int i = 0; i < 3; i++) step("stall_hold", last);
        flush_i = 1;
        step("flush_stall", BUB);
        flush_i = 0; stall_i = 0;

        // stall_i over own stall request holds; reset mid-stall bubbles
        set(32'h138, I_ORI, 1'b1);
        step("pre_stall2", mk(32'h138, 8'h25, 3'd1, 0, 32'h1100, 5'd1, 1, 0, 0));
        stall_i = 1;
        ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd4;
        set(32'h13C, I_OR, 1'b1);
        #1;
        chk("stall_req", {31'h0, stallreq_o}, 32'd1);
        step("stall_over_req", last);
        rst = 1;
        step("rst_mid_stall", BUB);
        rst = 0; stall_i = 0;
        clr_fwd();
        set(32'h140, I_ORI, 1'b0);
        step("post_rst", BUB);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
